// File: rtl/mem_req_issue_if.sv
// Data SRAM-like bus between the EXE memory issue unit and the data memory.
// The master drives the request fields; the slave returns the handshakes and read data.
interface mem_req_issue_if;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_req, data_sram_wr, data_sram_size,
        output data_sram_wstrb, data_sram_addr, data_sram_wdata,
        input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );

    modport slave (
        input  data_sram_req, data_sram_wr, data_sram_size,
        input  data_sram_wstrb, data_sram_addr, data_sram_wdata,
        output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );
endinterface

// File: rtl/mem_req_issue.sv
// EXE-stage data memory issue unit: translation, exception checks, multi-outstanding tracking.
// Define MEM_REQ_STAT_EN to add the stat_issued/stat_dropped/stat_stall counters.
module mem_req_issue #(
    parameter int NUM_DMW   = 2,
    parameter int MAX_OUTST = 2,
    parameter int CNT_W     = 3
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 op_valid,
    input  logic                 op_wr,
    input  logic [1:0]           op_size,
    input  logic [31:0]          op_vaddr,
    input  logic [31:0]          op_wdata,
    output logic                 op_ready,
    input  logic                 flush,
    input  logic [1:0]           crmd_plv,
    input  logic                 direct_mode,
    input  logic [3*NUM_DMW-1:0] dmw_vseg,
    input  logic [3*NUM_DMW-1:0] dmw_pseg,
    input  logic [NUM_DMW-1:0]   dmw_plv0,
    input  logic [NUM_DMW-1:0]   dmw_plv3,
    input  logic                 tlb_found,
    input  logic [19:0]          tlb_ppn,
    input  logic [5:0]           tlb_ps,
    input  logic [1:0]           tlb_plv,
    input  logic                 tlb_d,
    input  logic                 tlb_v,
    output logic                 exc_valid,
    output logic [2:0]           exc_code,
    mem_req_issue_if.master      dsram,
    output logic                 rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic [CNT_W-1:0]     inflight
`ifdef MEM_REQ_STAT_EN
    ,
    output logic [31:0]          stat_issued,
    output logic [31:0]          stat_dropped,
    output logic [31:0]          stat_stall
`endif
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTST);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    typedef enum logic {RUN, DRAIN} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic             rsp_valid_q;
    logic [31:0]      rsp_rdata_q;

    logic        plv0, plv3, dmw_hit, use_tlb;
    logic [31:0] dmw_pa, tlb_pa, paddr;
    logic        misalign, fault;
    logic [2:0]  code;
    logic        hs, dok, drop, keep;

    assign plv0 = (crmd_plv == 2'd0);
    assign plv3 = (crmd_plv == 2'd3);

    // Scan downwards so the lowest-index hitting window is the one left standing.
    always_comb begin
        dmw_hit = 1'b0;
        dmw_pa  = '0;
        for (int i = NUM_DMW - 1; i >= 0; i--) begin
            if (op_vaddr[31:29] == dmw_vseg[3*i +: 3] &&
                ((plv0 && dmw_plv0[i]) || (plv3 && dmw_plv3[i]))) begin
                dmw_hit = 1'b1;
                dmw_pa  = {dmw_pseg[3*i +: 3], op_vaddr[28:0]};
            end
        end
    end

    assign tlb_pa  = (tlb_ps == 6'd22) ? {tlb_ppn[19:10], op_vaddr[21:0]}
                                       : {tlb_ppn, op_vaddr[11:0]};
    assign use_tlb = ~direct_mode & ~dmw_hit;
    assign paddr   = direct_mode ? op_vaddr : (dmw_hit ? dmw_pa : tlb_pa);

    always_comb begin
        misalign = 1'b0;
        case (op_size)
            2'd0:    misalign = 1'b0;
            2'd1:    misalign = op_vaddr[0];
            default: misalign = |op_vaddr[1:0];
        endcase
    end

    always_comb begin
        fault = 1'b1;
        code  = 3'd0;
        priority case (1'b1)
            misalign:                                   code = 3'd0;
            plv3 && op_vaddr[31] && !dmw_hit && !direct_mode:
                                                        code = 3'd1;
            use_tlb && !tlb_found:                      code = 3'd2;
            use_tlb && !tlb_v && !op_wr:                code = 3'd3;
            use_tlb && !tlb_v && op_wr:                 code = 3'd4;
            use_tlb && (crmd_plv > tlb_plv):            code = 3'd5;
            use_tlb && op_wr && !tlb_d:                 code = 3'd6;
            default:                                    fault = 1'b0;
        endcase
    end

    always_comb begin
        dsram.data_sram_wr   = op_wr;
        dsram.data_sram_size = op_size;
        dsram.data_sram_addr = paddr;
        case (op_size)
            2'd0: begin
                dsram.data_sram_wstrb = 4'b0001 << op_vaddr[1:0];
                dsram.data_sram_wdata = {4{op_wdata[7:0]}};
            end
            2'd1: begin
                dsram.data_sram_wstrb = 4'b0011 << op_vaddr[1:0];
                dsram.data_sram_wdata = {2{op_wdata[15:0]}};
            end
            default: begin
                dsram.data_sram_wstrb = 4'hF;
                dsram.data_sram_wdata = op_wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= RUN;
            inflight_q  <= '0;
            discard_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            inflight_q  <= inflight_d;
            discard_q   <= discard_d;
            rsp_valid_q <= keep;
            if (keep) rsp_rdata_q <= dsram.data_sram_rdata;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:   if (flush && discard_d != '0) state_d = DRAIN;
            DRAIN: if (discard_d == '0)          state_d = RUN;
        endcase
    end

    always_comb begin
        dsram.data_sram_req = resetn & op_valid & ~fault & ~flush &
                              (state_q == RUN) & (inflight_q < MAX_C);
        exc_valid = resetn & op_valid & fault & ~flush;
        exc_code  = exc_valid ? code : 3'd0;
        hs        = dsram.data_sram_req & dsram.data_sram_addr_ok;
        op_ready  = hs | exc_valid;
    end

    // A data_ok with nothing outstanding is spurious and is ignored outright.
    assign dok  = dsram.data_sram_data_ok & (inflight_q != '0);
    assign drop = dok & (discard_q != '0);
    assign keep = dok & (discard_q == '0);

    assign inflight_d = inflight_q + (hs ? ONE_C : '0) - (dok ? ONE_C : '0);
    assign discard_d  = flush ? inflight_d
                              : (drop ? discard_q - ONE_C : discard_q);

    assign inflight  = inflight_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

`ifdef MEM_REQ_STAT_EN
    logic [31:0] issued_q, dropped_q, stall_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            issued_q  <= '0;
            dropped_q <= '0;
            stall_q   <= '0;
        end else begin
            issued_q  <= issued_q + 32'(hs);
            dropped_q <= dropped_q + 32'(drop);
            stall_q   <= stall_q + 32'(op_valid & ~fault & ~op_ready);
        end
    end

    assign stat_issued  = issued_q;
    assign stat_dropped = dropped_q;
    assign stat_stall   = stall_q;
`endif

endmodule
